// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button front end.
package key_pkg;

    localparam int DEB_W  = 20;
    localparam int HOLD_W = 26;

    localparam logic [DEB_W-1:0]  DEBOUNCE_CNT_DEF   = 20'd999_999;
    localparam logic [HOLD_W-1:0] LONG_PRESS_CNT_DEF = 26'd49_999_999;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } key_state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an active-low key; both stages reset to the released level.
// Latency 2 cycles, no backpressure.
module key_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_vaild_ctrl.sv
// Debounced key FSM producing press/release/long pulses and the toggled vaild level.
// Optional long-press path under KEY_LONG_PRESS_EN; all outputs registered, no backpressure.
module key_vaild_ctrl
    import key_pkg::*;
#(
    parameter logic [DEB_W-1:0]  DEBOUNCE_CNT   = DEBOUNCE_CNT_DEF,
    parameter logic [HOLD_W-1:0] LONG_PRESS_CNT = LONG_PRESS_CNT_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_n,
    output logic vaild,
    output logic key_press,
    output logic key_release,
    output logic long_press
);

    // The detecting cycle in IDLE/DOWN is the first sample of the window,
    // so the filter state needs DEBOUNCE_CNT more (expects DEBOUNCE_CNT >= 2).
    localparam logic [DEB_W-1:0] DEB_LAST = DEBOUNCE_CNT - 20'd1;

    logic             w_key_s;
    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [DEB_W-1:0] w_deb_cnt_nxt;
    logic             r_vaild;
    logic             w_vaild_nxt;
    logic             r_key_press;
    logic             w_press_nxt;
    logic             r_key_release;
    logic             w_release_nxt;
    logic             w_long_flag;

`ifdef KEY_LONG_PRESS_EN
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_long_flag;
    logic              w_long_flag_nxt;
    logic              r_long_press;
    logic              w_long_nxt;

    assign w_long_flag = r_long_flag;
`else
    logic w_unused_long;

    assign w_unused_long = ^LONG_PRESS_CNT;
    assign w_long_flag   = 1'b0;
`endif

    key_sync u_key_sync (
        .i_clk   (sys_clk),
        .i_rst_n (rst_n),
        .i_d     (key_n),
        .o_q     (w_key_s)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_deb_cnt_nxt = r_deb_cnt;
        w_vaild_nxt   = r_vaild;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef KEY_LONG_PRESS_EN
        w_hold_nxt      = r_hold_cnt;
        w_long_flag_nxt = r_long_flag;
        w_long_nxt      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_key_s) begin
                    w_state_nxt   = PRESS_FILT;
                    w_deb_cnt_nxt = '0;
                end
            end
            PRESS_FILT: begin
                if (w_key_s) begin
                    w_state_nxt = IDLE;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = DOWN;
                    w_press_nxt = 1'b1;
`ifdef KEY_LONG_PRESS_EN
                    w_hold_nxt      = '0;
                    w_long_flag_nxt = 1'b0;
`endif
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 20'd1;
                end
            end
            DOWN: begin
`ifdef KEY_LONG_PRESS_EN
                if (r_hold_cnt != LONG_PRESS_CNT) begin
                    w_hold_nxt = r_hold_cnt + 26'd1;
                end
`endif
                if (w_key_s) begin
                    w_state_nxt   = REL_FILT;
                    w_deb_cnt_nxt = '0;
                end
            end
            REL_FILT: begin
                if (!w_key_s) begin
                    w_state_nxt = DOWN;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    if (!w_long_flag) begin
                        w_vaild_nxt = !r_vaild;
                    end
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 20'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
`ifdef KEY_LONG_PRESS_EN
        // Hold is frozen in REL_FILT, so the threshold can still be noticed there.
        if ((r_state == DOWN || r_state == REL_FILT) &&
            (r_hold_cnt == LONG_PRESS_CNT) && !r_long_flag) begin
            w_long_flag_nxt = 1'b1;
            w_long_nxt      = 1'b1;
            w_vaild_nxt     = 1'b0;
        end
`endif
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_deb_cnt     <= '0;
            r_vaild       <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_deb_cnt     <= w_deb_cnt_nxt;
            r_vaild       <= w_vaild_nxt;
            r_key_press   <= w_press_nxt;
            r_key_release <= w_release_nxt;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt   <= '0;
            r_long_flag  <= 1'b0;
            r_long_press <= 1'b0;
        end else begin
            r_hold_cnt   <= w_hold_nxt;
            r_long_flag  <= w_long_flag_nxt;
            r_long_press <= w_long_nxt;
        end
    end

    assign long_press = r_long_press;
`else
    assign long_press = 1'b0;
`endif

    assign vaild       = r_vaild;
    assign key_press   = r_key_press;
    assign key_release = r_key_release;

endmodule

// File: tb/tb_key_vaild_ctrl.sv
// Bench for key_vaild_ctrl: directed timing checks plus random key activity against a run-length model.
module tb_key_vaild_ctrl;

    localparam int D = 4;
    localparam int L = 20;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic sys_clk;
    logic rst_n;
    logic key_n;
    logic vaild;
    logic key_press;
    logic key_release;
    logic long_press;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int n_press = 0;
    int n_rel   = 0;
    int n_long  = 0;

    // Model state: sync pipe, debounced level, run of opposite samples, hold count.
    bit m_q1, m_q2, m_deb, m_flag, m_vaild, m_press, m_rel, m_long;
    int m_run, m_hold;

    key_vaild_ctrl #(
        .DEBOUNCE_CNT   (20'd4),
        .LONG_PRESS_CNT (26'd20)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .vaild       (vaild),
        .key_press   (key_press),
        .key_release (key_release),
        .long_press  (long_press)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic check(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q1 = 1; m_q2 = 1; m_deb = 0; m_run = 0; m_hold = 0; m_flag = 0;
            m_vaild = 0; m_press = 0; m_rel = 0; m_long = 0;
        end else begin
            bit s;
            int hold_pre;
            s = m_q2; m_q2 = m_q1; m_q1 = key_n;
            m_press = 0; m_rel = 0; m_long = 0;
            if (!m_deb) begin
                m_run = (s == 1'b0) ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    m_deb = 1; m_run = 0; m_press = 1; m_hold = 0; m_flag = 0;
                end
            end else begin
                hold_pre = m_hold;
                if (LONG_EN && m_run == 0 && m_hold < L) m_hold = m_hold + 1;
                if (LONG_EN && hold_pre == L && !m_flag) begin
                    m_flag = 1; m_long = 1; m_vaild = 0;
                end
                m_run = (s == 1'b1) ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    m_deb = 0; m_run = 0; m_rel = 1;
                    if (!m_flag) m_vaild = !m_vaild;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        n_press = n_press + int'(key_press);
        n_rel   = n_rel + int'(key_release);
        n_long  = n_long + int'(long_press);
        if (chk_en) begin
            check("vaild", vaild, m_vaild);
            check("key_press", key_press, m_press);
            check("key_release", key_release, m_rel);
            check("long_press", long_press, m_long);
            check("one_pulse", ($countones({key_press, key_release, long_press}) <= 1), 1);
        end
    end

    task automatic drive(input logic lvl, input int cycles);
        key_n = lvl;
        repeat (cycles) @(negedge sys_clk);
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_vaild", vaild, 0);
        check("rst_press", key_press, 0);
        check("rst_release", key_release, 0);
        check("rst_long", long_press, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        drive(1'b1, 10);
        check("idle_no_press", n_press, 0);
        check("idle_no_release", n_rel, 0);

        drive(1'b0, 3);
        drive(1'b1, 10);
        check("bounce_no_press", n_press, 0);
        check("bounce_vaild", vaild, 0);

        key_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (i == 6) check("press_cyc6", key_press, 0);
            if (i == 7) check("press_cyc7", key_press, 1);
            if (i == 8) check("press_cyc8", key_press, 0);
        end
        drive(1'b1, 10);
        check("short1_vaild", vaild, 1);
        check("short1_release_cnt", n_rel, 1);
        drive(1'b0, 10);
        drive(1'b1, 10);
        check("short2_vaild", vaild, 0);
        check("short2_press_cnt", n_press, 2);

        drive(1'b0, 15);
        drive(1'b1, 2);
        drive(1'b0, 6);
        check("glitch_no_release", n_rel, 2);
        drive(1'b1, 10);
        check("glitch_release_cnt", n_rel, 3);
        check("glitch_vaild", vaild, 1);

        drive(1'b0, 40);
        check("hold_vaild", vaild, LONG_EN ? 0 : 1);
        check("hold_long_cnt", n_long, LONG_EN ? 1 : 0);
        drive(1'b1, 10);
        check("hold_rel_vaild", vaild, 0);
        check("hold_release_cnt", n_rel, 4);

        drive(1'b0, 10);
        drive(1'b1, 10);
        check("pre_rst_vaild", vaild, 1);
        drive(1'b0, 12);
        #2 rst_n = 1'b0;
        #1 check("async_rst_vaild", vaild, 0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge sys_clk);
            if (i == 6) check("rst_press_cyc6", key_press, 0);
            if (i == 7) check("rst_press_cyc7", key_press, 1);
        end
        drive(1'b1, 10);
        check("rst_rel_vaild", vaild, 1);

        for (int b = 0; b < 400; b++) begin
            int dur;
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 45) : $urandom_range(1, 7);
            drive(1'($urandom_range(0, 1)), dur);
        end
        drive(1'b1, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_vaild_ctrl.md
# key_vaild_ctrl

Push-button front end that produces the `vaild` enable level consumed by the LED flasher. Synchronises and debounces one active-low board key, emits single-cycle press/release event pulses, and toggles the `vaild` level on each completed short press. An optional long-press path forces the flasher off. Runs on the 50 MHz system clock.

## Interface
- `DEBOUNCE_CNT`, 20'd999_999: debounce window in cycles minus one (20 ms at 50 MHz).
- `LONG_PRESS_CNT`, 26'd49_999_999: long-press threshold in cycles minus one (1 s at 50 MHz).
- `sys_clk`  in  1  system clock, 50 MHz; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  1  raw key, active-low, asynchronous to `sys_clk`, bouncing.
- `vaild`  out  1  enable level to LED flasher; 1 = flash.
- `key_press`  out  1  one-cycle pulse on debounced press.
- `key_release`  out  1  one-cycle pulse on debounced release.
- `long_press`  out  1  one-cycle pulse when hold reaches threshold (0 when feature compiled out).

## Operation
- `key_n` passes through a 2-flop synchroniser (both flops reset to 1); `key_s` = second flop; all logic uses `key_s` only.
- FSM states: IDLE, PRESS_FILT, DOWN, REL_FILT. Reset state IDLE.
- IDLE: `key_s`=0 -> PRESS_FILT, debounce counter cleared.
- PRESS_FILT: counter increments each cycle `key_s`=0; `key_s`=1 -> IDLE (bounce rejected, no pulse); counter == `DEBOUNCE_CNT` with `key_s`=0 -> DOWN, hold counter and long flag cleared.
- DOWN: hold counter increments, saturating at `LONG_PRESS_CNT`; `key_s`=1 -> REL_FILT, debounce counter cleared.
- REL_FILT: counter increments each cycle `key_s`=1; hold counter frozen; `key_s`=0 -> DOWN (bounce, hold count kept, no pulse); counter == `DEBOUNCE_CNT` with `key_s`=1 -> IDLE.
- Release completion (REL_FILT -> IDLE): `vaild` toggles unless long flag set; if long flag set, `vaild` unchanged (stays 0).
- Counters are unsigned; debounce 20 bits, hold 26 bits; no wrap (debounce bounded by transition, hold saturates).

## Timing
- Reset values: `vaild`=0, `key_press`=0, `key_release`=0, `long_press`=0, state IDLE, counters 0.
- Synchroniser latency 2 cycles from `key_n` edge to `key_s`.
- Press confirmed after `DEBOUNCE_CNT`+1 consecutive low `key_s` cycles; `key_press` high exactly the first cycle state = DOWN.
- `key_release` high exactly the first cycle state = IDLE after REL_FILT; `vaild` takes its new value in that same cycle.
- `long_press` high exactly one cycle, the cycle after hold counter reaches `LONG_PRESS_CNT`; `vaild` = 0 from that cycle.
- Only one pulse output high in any cycle; no pulse re-fires from a bounce inside REL_FILT.
- Reset mid-press: all state cleared asynchronously; key still held at reset release requires full new debounce window before `key_press`.

## Configuration
- `KEY_LONG_PRESS_EN` defined: hold counter, long flag and `long_press` pulse present; long hold forces `vaild`=0 and suppresses toggle at release.
- Undefined: hold counter and long flag removed; `long_press` tied 0; every debounced release toggles `vaild` regardless of hold duration; `LONG_PRESS_CNT` unused.

## Structure
- Shared package `key_pkg`: FSM state enum (IDLE, PRESS_FILT, DOWN, REL_FILT), default `DEBOUNCE_CNT`/`LONG_PRESS_CNT` constants, counter width constants.
- Sub-module `key_sync`: 2-flop synchroniser, reset value 1; reused for any future key inputs.
- Top `key_vaild_ctrl`: FSM, counters, output registers.

## Test plan (sim params `DEBOUNCE_CNT`=4, `LONG_PRESS_CNT`=20)
- Reset with `key_n`=1 -> all outputs 0, state IDLE; hold 10 cycles, no pulses.
- `key_n` low 3 cycles then high (bounce) -> no `key_press`, `vaild` stays 0, state returns IDLE.
- Clean press 10 cycles, release 10 cycles -> `key_press` 1 cycle at 7th cycle after falling edge (2 sync + 5 filter), `key_release` 1 cycle, `vaild` 0->1; repeat -> `vaild` 1->0.
- Press held, `key_n` glitches high 2 cycles mid-hold -> no `key_release`, no toggle; final release toggles once.
- With `KEY_LONG_PRESS_EN`, `vaild`=1, hold 40 cycles -> `long_press` 1 cycle, `vaild`=0 immediately, stays 0 after `key_release`; without macro same stimulus -> `long_press` never high, `vaild` toggles to 0 only at release.
- Assert `rst_n`=0 while in DOWN with `vaild`=1 -> outputs 0 asynchronously; release reset with key held -> `key_press` only after 5 further low `key_s` cycles.
